// File: rtl/fifo_load_sequencer.sv
// Streams an NxN matrix row-major into row FIFOs 0..N-1, then an N-byte vector into FIFO select 8.
// Optional size checking is enabled with the FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN macro.
module fifo_load_sequencer #(
  parameter int DW    = 8,
  parameter int MAX_N = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    size,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  input  logic          fifo_full,
  output logic          data_ready,
  output logic [3:0]    i,
  output logic [DW-1:0] Data,
  output logic          push,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [4:0] MAXN5 = 5'(MAX_N);
  localparam logic [3:0] MAXN4 = 4'(MAX_N);

  typedef enum logic [1:0] {IDLE, LOAD_MAT, LOAD_VEC, FINISH} state_t;

  state_t     state, state_nxt;
  logic [3:0] n, n_nxt;
  logic [3:0] row, row_nxt;
  logic [3:0] col, col_nxt;
  logic       err_nxt;
  logic       accept;
  logic       size_ok;
  logic [3:0] size_eff;
  logic [3:0] last_idx;

  assign data_ready = ((state == LOAD_MAT) || (state == LOAD_VEC)) && !fifo_full;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign last_idx   = n - 4'd1;

  // Out-of-range sizes are either rejected or clamped to the largest supported matrix.
  always_comb begin
    size_ok  = 1'b1;
    size_eff = size;
`ifdef FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN
    size_ok  = (size != 4'd0) && ({1'b0, size} <= MAXN5);
`else
    if ((size == 4'd0) || ({1'b0, size} > MAXN5)) begin
      size_eff = MAXN4;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    row_nxt   = row;
    col_nxt   = col;
    err_nxt   = error;
    case (state)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            n_nxt     = size_eff;
            row_nxt   = 4'd0;
            col_nxt   = 4'd0;
            err_nxt   = 1'b0;
            state_nxt = LOAD_MAT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD_MAT: begin
        if (accept) begin
          if (col == last_idx) begin
            col_nxt = 4'd0;
            if (row == last_idx) begin
              state_nxt = LOAD_VEC;
            end else begin
              row_nxt = row + 4'd1;
            end
          end else begin
            col_nxt = col + 4'd1;
          end
        end
      end
      LOAD_VEC: begin
        if (accept) begin
          if (col == last_idx) begin
            state_nxt = FINISH;
          end else begin
            col_nxt = col + 4'd1;
          end
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      n     <= 4'd0;
      row   <= 4'd0;
      col   <= 4'd0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      error <= err_nxt;
    end
  end

  // One register stage between an accepted byte and its push; select 15 means no FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i    <= 4'd15;
      Data <= '0;
      push <= 1'b0;
    end else begin
      push <= accept;
      if (accept) begin
        Data <= data_in;
        i    <= (state == LOAD_MAT) ? row : 4'd8;
      end else begin
        i <= 4'd15;
      end
    end
  end

endmodule

// File: tb/tb_fifo_load_sequencer.sv
// Self-checking bench for fifo_load_sequencer: directed sessions plus randomized bytes, gaps and
// back-pressure, compared against an index-arithmetic model of the expected push stream.
module tb_fifo_load_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] size = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       data_ready;
  logic [3:0] i;
  logic [7:0] Data;
  logic       push;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       busy;
    logic [3:0] idx;
    logic [7:0] data;
  } push_t;

  push_t pushLog[$];
  int    doneCount = 0;
  int    latErr = 0;
  int    idleIErr = 0;
  int    badIErr = 0;
  int    readyErr = 0;
  int    holdErr = 0;
  logic  prevAcc = 1'b0;
  logic [7:0] lastData = 8'd0;

  fifo_load_sequencer #(.DW(8), .MAX_N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .size       (size),
    .data_in    (data_in),
    .data_valid (data_valid),
    .fifo_full  (fifo_full),
    .data_ready (data_ready),
    .i          (i),
    .Data       (Data),
    .push       (push),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Mid-cycle observer: logs every push and tallies protocol violations for later comparison.
  always @(negedge clk) begin
    if (!reset) begin
      prevAcc  = 1'b0;
      lastData = 8'd0;
    end else begin
      if (push !== prevAcc) latErr++;
      if (push) pushLog.push_back(push_t'({busy, i, Data}));
      else if (Data !== lastData) holdErr++;
      lastData = Data;
      if (done) doneCount++;
      if (!push && !busy && i !== 4'd15) idleIErr++;
      if (i >= 4'd9 && i <= 4'd14) badIErr++;
      if ((fifo_full || !busy) && data_ready) readyErr++;
      prevAcc = data_valid && data_ready;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart(input logic [3:0] sz);
    @(posedge clk); #1;
    start = 1'b1;
    size  = sz;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until the DUT takes it, optionally with a gap or back-pressure.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int t;
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      data_valid = 1'b0;
      @(posedge clk); #1;
    end
    fifo_full  = gaps && ($urandom_range(0, 4) == 0);
    data_in    = b;
    data_valid = 1'b1;
    t = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = data_ready;
      @(posedge clk); #1;
      fifo_full = 1'b0;
      t++;
    end while (!acc && t < 100);
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic runSession(input logic [3:0] sz, input logic [7:0] bytes[$], input bit gaps,
                            input bit midStart, input bit stall, input string tag);
    push_t      exp[$];
    int         n;
    int         base;
    int         d0;
    logic [7:0] b;
    n    = (sz == 4'd0 || sz > 4'd8) ? 8 : int'(sz);
    base = pushLog.size();
    d0   = doneCount;
    pulseStart(sz);
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < n * n + n; k++) begin
      b = (bytes.size() > k) ? bytes[k] : 8'($urandom);
      exp.push_back(push_t'({1'b1, (k < n * n) ? 4'(k / n) : 4'd8, b}));
      if (stall && k == 2) begin
        data_in    = b;
        data_valid = 1'b1;
        fifo_full  = 1'b1;
        repeat (4) begin
          @(negedge clk);
          checkOutput({tag, "_stall_ready"}, 32'(data_ready), 32'd0);
        end
        @(posedge clk); #1;
        checkOutput({tag, "_stall_pushes"}, 32'(pushLog.size() - base), 32'd2);
        fifo_full = 1'b0;
      end
      if (midStart && k == 3) begin
        start = 1'b1;
        size  = 4'd2;
      end
      applyStimulus(b, gaps);
      start = 1'b0;
    end
    data_valid = 1'b0;
    fifo_full  = 1'b0;
    checkOutput({tag, "_done_now"}, 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_push_count"}, 32'(pushLog.size() - base), 32'(exp.size()));
    for (int k = 0; k < exp.size() && base + k < pushLog.size(); k++)
      checkOutput($sformatf("%s_push%0d", tag, k), 32'(pushLog[base + k]), 32'(exp[k]));
    checkOutput({tag, "_done_once"}, 32'(doneCount - d0), 32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] noBytes[$];
    logic [7:0] dirBytes[$];
    int         base;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_i", 32'(i), 32'd15);
    checkOutput("rst_data", 32'(Data), 32'd0);
    checkOutput("rst_push", 32'(push), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_ready", 32'(data_ready), 32'd0);
    reset = 1'b1;

    dirBytes = '{8'd11, 8'd12, 8'd21, 8'd22, 8'd5, 8'd6};
    runSession(4'd2, dirBytes, 1'b0, 1'b0, 1'b0, "n2_directed");
    runSession(4'd8, noBytes, 1'b0, 1'b0, 1'b0, "n8_full");
    runSession(4'd3, noBytes, 1'b0, 1'b0, 1'b1, "n3_stall");
    runSession(4'd4, noBytes, 1'b1, 1'b1, 1'b0, "n4_midstart");
    for (int s = 0; s < 4; s++)
      runSession(4'($urandom_range(1, 8)), noBytes, 1'b1, 1'b0, 1'b0, $sformatf("rand%0d", s));

    // Abort a size-4 session after five bytes with an asynchronous reset.
    base = pushLog.size();
    pulseStart(4'd4);
    for (int k = 0; k < 5; k++) applyStimulus(8'($urandom), 1'b0);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_i", 32'(i), 32'd15);
    checkOutput("abort_data", 32'(Data), 32'd0);
    checkOutput("abort_push", 32'(push), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_error", 32'(error), 32'd0);
    checkOutput("abort_ready", 32'(data_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("abort_pushes", 32'(pushLog.size() - base), 32'd4);
    base = pushLog.size();
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("post_reset_ready", 32'(data_ready), 32'd0);
    end
    checkOutput("post_reset_pushes", 32'(pushLog.size() - base), 32'd0);
    data_valid = 1'b0;
    runSession(4'd1, noBytes, 1'b0, 1'b0, 1'b0, "n1_after_reset");

`ifdef FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN
    base = pushLog.size();
    pulseStart(4'd9);
    checkOutput("bad_size_error", 32'(error), 32'd1);
    checkOutput("bad_size_busy", 32'(busy), 32'd0);
    data_in    = 8'hAA;
    data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bad_size_ready", 32'(data_ready), 32'd0);
    checkOutput("bad_size_pushes", 32'(pushLog.size() - base), 32'd0);
    data_valid = 1'b0;
    runSession(4'd2, noBytes, 1'b0, 1'b0, 1'b0, "n2_after_error");
    checkOutput("error_cleared", 32'(error), 32'd0);
`else
    runSession(4'd9, noBytes, 1'b0, 1'b0, 1'b0, "n9_clamped");
    checkOutput("clamp_error", 32'(error), 32'd0);
`endif

    checkOutput("latency", 32'(latErr), 32'd0);
    checkOutput("idle_select", 32'(idleIErr), 32'd0);
    checkOutput("illegal_select", 32'(badIErr), 32'd0);
    checkOutput("ready_rule", 32'(readyErr), 32'd0);
    checkOutput("data_hold", 32'(holdErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_load_sequencer.md
FIFO_LOAD_SEQUENCER -- requirements
Module: fifo_load_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8, the data byte width.
REQ-002 SHALL have parameter MAX_N, default 8, the maximum matrix dimension and the number of row FIFOs.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port size  input  4  matrix dimension N, sampled on an accepted start.
REQ-007 SHALL have port data_in  input  DW  incoming byte stream.
REQ-008 SHALL have port data_valid  input  1  data_in holds a valid byte.
REQ-009 SHALL have port fifo_full  input  1  the currently addressed FIFO cannot take a push.
REQ-010 SHALL have port data_ready  output  1  byte accepted this cycle when data_valid and data_ready are both high.
REQ-011 SHALL have port i  output  4  FIFO select code: 0..7 for row FIFOs, 8 for both vector FIFOs, 15 when idle.
REQ-012 SHALL have port Data  output  DW  registered byte for the selected FIFO.
REQ-013 SHALL have port push  output  1  registered one-cycle push strobe.
REQ-014 SHALL have port busy  output  1  a session is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a session completes.
REQ-016 SHALL have port error  output  1  sticky flag for an invalid size; cleared by the next accepted start.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD_MAT, LOAD_VEC and FINISH.
REQ-018 IDLE: on start, SHALL latch N=size, clear the row/col counters, and enter LOAD_MAT; a start in any other state SHALL be ignored.
REQ-019 SHALL drive data_ready = (state is LOAD_MAT or LOAD_VEC) AND NOT fifo_full; data_ready SHALL be 0 in IDLE and FINISH.
REQ-020 LOAD_MAT: each accepted byte SHALL be routed to row FIFO "row" (i=row); col SHALL increment, and on col=N-1 it SHALL wrap to 0 and row SHALL increment.
REQ-021 SHALL order the matrix stream row-major and SHALL accept exactly N*N bytes; the acceptance of byte (N-1,N-1) SHALL transition to LOAD_VEC with col=0.
REQ-022 LOAD_VEC: each accepted byte SHALL be routed with i=8; after exactly N bytes the FSM SHALL enter FINISH.
REQ-023 FINISH: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 Latency: a byte accepted at edge k SHALL appear on Data, with push=1 and the matching i, during cycle k+1 (one register stage).
REQ-025 push SHALL be 0 in every cycle following a non-accepting edge; Data SHALL hold its last value when push=0.
REQ-026 i SHALL equal 15 whenever push=0 and the state is IDLE, so that no FIFO is selected.
REQ-027 busy SHALL be 1 from the edge that accepts start through the FINISH cycle inclusive.
REQ-028 When fifo_full rises mid-row, SHALL stall with the counters unchanged and SHALL drop no byte.
REQ-029 With N=1, SHALL load exactly one matrix byte (i=0) followed by one vector byte (i=8).
REQ-030 Counters SHALL be 4 bits wide; row SHALL never exceed N-1 and no i value in 9..14 SHALL ever be generated.

Reset
REQ-031 Asserting reset at any time, including mid-session, SHALL immediately force IDLE and the following output values: i=15, Data=0, push=0, busy=0, done=0, error=0, data_ready=0, N=0, row=0, col=0.
REQ-032 After reset deasserts, the block SHALL accept no byte until a new start.

Configuration
REQ-033 SHALL support the macro FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN.
REQ-034 With FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN defined: a start with size=0 or size>MAX_N SHALL set error=1 and leave the FSM in IDLE.
REQ-035 Without FIFO_LOAD_SEQUENCER_SIZE_CHECK_EN: error SHALL be tied to 0, size=0 SHALL be treated as MAX_N, and size>MAX_N SHALL be clamped to MAX_N.

Verification
REQ-036 Verification SHALL cover: start with size=2, then bytes 11,12,21,22,5,6 with continuous valid -> pushes with (i,Data) = (0,11),(0,12),(1,21),(1,22),(8,5),(8,6), then done pulses exactly once.
REQ-037 Verification SHALL cover: size=8 full load of 64+8 bytes -> 8 pushes per i=0..7 in order, 8 pushes at i=8, busy high throughout, done once.
REQ-038 Verification SHALL cover: size=3 with fifo_full held high for 4 cycles after the 2nd byte -> data_ready=0 during the stall, no push, no byte lost, total pushes = 12.
REQ-039 Verification SHALL cover: reset pulsed after 5 bytes of a size=4 session -> all outputs at reset values in the same cycle; a new start with size=1 then loads bytes at i=0 and i=8.
REQ-040 Verification SHALL cover: size=9 with the macro defined -> error=1, busy=0, no push; without the macro -> a session of 8x8 runs.
REQ-041 Verification SHALL cover: start pulsed mid-session -> ignored, byte counts unchanged.
